// File: rtl/dpram_loader.sv
// dpram_loader: sequential clear/load engine for dpram port A, returning the port to the core when idle
// Parameters: AW address width, DW data width, FILL_VALUE word written by a clear.
// Ports: clock/reset (sync, active-high); clear_start/load_start start pulses;
//   dl_valid/dl_data/dl_last/dl_ready download stream; core_address/core_data/core_wren/core_q core port A;
//   address_a/data_a/wren_a/q_a dpram port A; busy/done/word_count/truncated/verify_err status.
// Optional: define DPRAM_LOADER_VERIFY_EN to add a readback checksum pass after each load.
module dpram_loader #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter logic [DW-1:0] FILL_VALUE = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_start,
  input  logic          load_start,
  input  logic          dl_valid,
  input  logic [DW-1:0] dl_data,
  input  logic          dl_last,
  output logic          dl_ready,
  input  logic [AW-1:0] core_address,
  input  logic [DW-1:0] core_data,
  input  logic          core_wren,
  output logic [DW-1:0] core_q,
  output logic [AW-1:0] address_a,
  output logic [DW-1:0] data_a,
  output logic          wren_a,
  input  logic [DW-1:0] q_a,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   word_count,
  output logic          truncated,
  output logic          verify_err
);
`ifdef DPRAM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, VREAD, VCMP} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLEAR, LOAD} state_t;
`endif
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0] wc_q, wc_d;
  logic trunc_q, trunc_d, done_q, done_d;
  logic last_addr;
`ifdef DPRAM_LOADER_VERIFY_EN
  logic [DW-1:0] sum_q, sum_d, acc_q, acc_d;
  logic verr_q, verr_d;
  assign verify_err = verr_q;
`else
  assign verify_err = 1'b0;
`endif
  assign last_addr = addr_q == '1;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign word_count = wc_q;
  assign truncated = trunc_q;
  assign core_q = q_a;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wc_d = wc_q;
    trunc_d = trunc_q;
    done_d = 1'b0;
    address_a = core_address;
    data_a = core_data;
    wren_a = core_wren;
    dl_ready = 1'b0;
`ifdef DPRAM_LOADER_VERIFY_EN
    sum_d = sum_q;
    acc_d = acc_q;
    verr_d = verr_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          addr_d = '0;
        end else if (load_start) begin
          state_d = LOAD;
          addr_d = '0;
          trunc_d = 1'b0;
`ifdef DPRAM_LOADER_VERIFY_EN
          sum_d = '0;
          verr_d = 1'b0;
`endif
        end
      end
      CLEAR: begin
        address_a = addr_q;
        data_a = FILL_VALUE;
        wren_a = 1'b1;
        addr_d = addr_q + AW'(1);
        if (last_addr) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
      LOAD: begin
        dl_ready = 1'b1;
        address_a = addr_q;
        data_a = dl_data;
        wren_a = dl_valid;
        if (dl_valid) begin
          addr_d = addr_q + AW'(1);
          wc_d = {1'b0, addr_q} + (AW+1)'(1);
`ifdef DPRAM_LOADER_VERIFY_EN
          sum_d = sum_q + dl_data;
`endif
          if (dl_last || last_addr) begin
            // exiting without dl_last can only mean the RAM filled up
            trunc_d = !dl_last;
`ifdef DPRAM_LOADER_VERIFY_EN
            state_d = VREAD;
            addr_d = '0;
            acc_d = '0;
`else
            state_d = IDLE;
            done_d = 1'b1;
`endif
          end
        end
      end
`ifdef DPRAM_LOADER_VERIFY_EN
      VREAD: begin
        address_a = addr_q;
        wren_a = 1'b0;
        // q_a lags the issued address by one cycle, so nothing is valid on the first read
        acc_d = addr_q != '0 ? acc_q + q_a : acc_q;
        if ({1'b0, addr_q} == wc_q - (AW+1)'(1)) state_d = VCMP;
        else addr_d = addr_q + AW'(1);
      end
      VCMP: begin
        address_a = addr_q;
        wren_a = 1'b0;
        verr_d = (acc_q + q_a) != sum_q;
        state_d = IDLE;
        done_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wc_q <= '0;
      trunc_q <= 1'b0;
      done_q <= 1'b0;
`ifdef DPRAM_LOADER_VERIFY_EN
      sum_q <= '0;
      acc_q <= '0;
      verr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wc_q <= wc_d;
      trunc_q <= trunc_d;
      done_q <= done_d;
`ifdef DPRAM_LOADER_VERIFY_EN
      sum_q <= sum_d;
      acc_q <= acc_d;
      verr_q <= verr_d;
`endif
    end
  end
endmodule

// File: tb/tb_dpram_loader.sv
// tb_dpram_loader: directed self-checking bench for dpram_loader with a behavioural dpram port A
module tb_dpram_loader;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [DW-1:0] FILL = 8'hA5;
  logic clock = 0, reset = 1, clear_start = 0, load_start = 0;
  logic dl_valid = 0, dl_last = 0, core_wren = 0, corrupt = 0;
  logic [DW-1:0] dl_data = '0, core_data = '0;
  logic [AW-1:0] core_address = '0;
  logic [DW-1:0] core_q, data_a, q_a;
  logic [AW-1:0] address_a;
  logic wren_a, dl_ready, busy, done, truncated, verify_err;
  logic [AW:0] word_count;
  logic [DW-1:0] mem [2**AW];
  int checks = 0, fails = 0;

  dpram_loader #(.AW(AW), .DW(DW), .FILL_VALUE(FILL)) dut (
    .clock(clock), .reset(reset), .clear_start(clear_start), .load_start(load_start),
    .dl_valid(dl_valid), .dl_data(dl_data), .dl_last(dl_last), .dl_ready(dl_ready),
    .core_address(core_address), .core_data(core_data), .core_wren(core_wren), .core_q(core_q),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .q_a(q_a),
    .busy(busy), .done(done), .word_count(word_count), .truncated(truncated), .verify_err(verify_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wren_a) mem[address_a] <= data_a;
    else if (corrupt) mem[2] <= ~mem[2];
    q_a <= mem[address_a];
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1;
    tick;
    tick;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (dl_ready !== 1'b0) begin fails++; $display("FAIL reset_dl_ready: got %b expected 0", dl_ready); end
    checks++; if (word_count !== 5'd0) begin fails++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
    checks++; if (truncated !== 1'b0) begin fails++; $display("FAIL reset_truncated: got %b expected 0", truncated); end
    checks++; if (verify_err !== 1'b0) begin fails++; $display("FAIL reset_verify_err: got %b expected 0", verify_err); end
    reset = 0;
    core_address = 4'd7; core_data = 8'h3C; core_wren = 1;
    #1;
    checks++;
    if (address_a !== 4'd7 || data_a !== 8'h3C || wren_a !== 1'b1) begin
      fails++; $display("FAIL idle_passthrough: got addr=%0d data=%h wren=%b expected addr=7 data=3c wren=1", address_a, data_a, wren_a);
    end
    tick;
    core_wren = 0;
    checks++; if (mem[7] !== 8'h3C) begin fails++; $display("FAIL core_write: got %h expected 3c", mem[7]); end
    checks++; if (core_q !== q_a) begin fails++; $display("FAIL core_q: got %h expected %h", core_q, q_a); end
  endtask

  task automatic test_clear;
    int bad = 0;
    clear_start = 1; load_start = 1;
    core_address = 4'd3; core_data = 8'h77; core_wren = 1;
    tick;
    clear_start = 0; load_start = 0;
    #1;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL clear_busy_rise: got %b expected 1", busy); end
    checks++; if (dl_ready !== 1'b0) begin fails++; $display("FAIL clear_wins_dl_ready: got %b expected 0", dl_ready); end
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (wren_a !== 1'b1 || address_a !== AW'(i) || data_a !== FILL || done !== 1'b0) begin
        fails++; $display("FAIL clear_write_%0d: got wren=%b addr=%0d data=%h done=%b expected wren=1 addr=%0d data=a5 done=0", i, wren_a, address_a, data_a, done, i);
      end
      tick;
    end
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL clear_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
    core_wren = 0;
    tick;
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL clear_done_pulse: got %b expected 0", done); end
    for (int i = 0; i < 16; i++) if (mem[i] !== FILL) bad++;
    checks++; if (bad != 0) begin fails++; $display("FAIL clear_ram: got %0d words not a5 (mem[7]=%h) expected 0", bad, mem[7]); end
    checks++; if (word_count !== 5'd0) begin fails++; $display("FAIL clear_load_ignored: got word_count=%0d expected 0", word_count); end
  endtask

  task automatic test_load;
    logic [DW-1:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_start = 1;
    tick;
    load_start = 0;
    #1;
    checks++;
    if (busy !== 1'b1 || dl_ready !== 1'b1 || wren_a !== 1'b0) begin
      fails++; $display("FAIL load_enter: got busy=%b dl_ready=%b wren=%b expected 1 1 0", busy, dl_ready, wren_a);
    end
    for (int k = 0; k < 4; k++) begin
      dl_valid = 1; dl_data = d[k]; dl_last = (k == 3);
      #1;
      checks++;
      if (wren_a !== 1'b1 || address_a !== AW'(k) || data_a !== d[k]) begin
        fails++; $display("FAIL load_beat_%0d: got wren=%b addr=%0d data=%h expected wren=1 addr=%0d data=%h", k, wren_a, address_a, data_a, k, d[k]);
      end
      tick;
      dl_valid = 0; dl_last = 0;
      if (k < 3) begin
        #1;
        checks++;
        if (wren_a !== 1'b0 || done !== 1'b0) begin
          fails++; $display("FAIL load_gap_%0d: got wren=%b done=%b expected 0 0", k, wren_a, done);
        end
        tick;
      end
    end
`ifdef DPRAM_LOADER_VERIFY_EN
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL load_verify_busy_%0d: got done=%b busy=%b expected 0 1", n, done, busy);
      end
      tick;
    end
`endif
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL load_done: got done=%b busy=%b expected 1 0", done, busy); end
    checks++; if (word_count !== 5'd4) begin fails++; $display("FAIL load_word_count: got %0d expected 4", word_count); end
    checks++; if (truncated !== 1'b0) begin fails++; $display("FAIL load_truncated: got %b expected 0", truncated); end
    checks++; if (verify_err !== 1'b0) begin fails++; $display("FAIL load_verify_err: got %b expected 0", verify_err); end
    checks++;
    if (mem[0] !== 8'h11 || mem[1] !== 8'h22 || mem[2] !== 8'h33 || mem[3] !== 8'h44 || mem[4] !== FILL) begin
      fails++; $display("FAIL load_ram: got %h %h %h %h %h expected 11 22 33 44 a5", mem[0], mem[1], mem[2], mem[3], mem[4]);
    end
    tick;
  endtask

  task automatic test_truncate;
    int n = 0;
    load_start = 1;
    tick;
    load_start = 0;
    for (int i = 0; i < 20; i++) begin
      dl_valid = 1; dl_data = DW'(i + 1); dl_last = 0;
      #1;
      checks++;
      if (dl_ready !== (i < 16)) begin
        fails++; $display("FAIL trunc_dl_ready_%0d: got %b expected %b", i, dl_ready, i < 16);
      end
      tick;
    end
    dl_valid = 0;
    while (busy && n < 40) begin tick; n++; end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL trunc_timeout: got busy=%b expected 0", busy); end
    checks++; if (truncated !== 1'b1) begin fails++; $display("FAIL trunc_flag: got %b expected 1", truncated); end
    checks++; if (word_count !== 5'd16) begin fails++; $display("FAIL trunc_word_count: got %0d expected 16", word_count); end
    checks++; if (mem[0] !== 8'h01 || mem[15] !== 8'h10) begin fails++; $display("FAIL trunc_ram: got %h %h expected 01 10", mem[0], mem[15]); end
    checks++; if (verify_err !== 1'b0) begin fails++; $display("FAIL trunc_verify_err: got %b expected 0", verify_err); end
  endtask

`ifdef DPRAM_LOADER_VERIFY_EN
  task automatic test_verify;
    int n = 0;
    load_start = 1;
    tick;
    load_start = 0;
    for (int k = 0; k < 4; k++) begin
      dl_valid = 1; dl_data = DW'(k + 5); dl_last = (k == 3);
      tick;
    end
    dl_valid = 0; dl_last = 0;
    corrupt = 1;
    tick;
    corrupt = 0;
    while (!done && n < 20) begin tick; n++; end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL verify_timeout: got done=%b expected 1", done); end
    checks++; if (verify_err !== 1'b1) begin fails++; $display("FAIL verify_err_set: got %b expected 1", verify_err); end
    load_start = 1;
    tick;
    load_start = 0;
    checks++; if (verify_err !== 1'b0) begin fails++; $display("FAIL verify_err_clear: got %b expected 0", verify_err); end
    dl_valid = 1; dl_data = 8'h99; dl_last = 1;
    tick;
    dl_valid = 0; dl_last = 0;
    n = 0;
    while (busy && n < 20) begin tick; n++; end
    checks++; if (busy !== 1'b0 || verify_err !== 1'b0) begin fails++; $display("FAIL verify_reload: got busy=%b verify_err=%b expected 0 0", busy, verify_err); end
  endtask
`endif

  task automatic test_reset_abort;
    int seen = 0;
    load_start = 1;
    tick;
    load_start = 0;
    dl_valid = 1; dl_data = 8'hB1;
    tick;
    dl_data = 8'hB2;
    tick;
    dl_data = 8'hB3; reset = 1;
    tick;
    reset = 0; dl_valid = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dl_ready !== 1'b0 || word_count !== 5'd0) begin
      fails++; $display("FAIL abort_state: got busy=%b done=%b dl_ready=%b word_count=%0d expected 0 0 0 0", busy, done, dl_ready, word_count);
    end
    core_address = 4'd5; core_data = 8'h5A; core_wren = 0;
    #1;
    checks++;
    if (address_a !== 4'd5 || data_a !== 8'h5A || wren_a !== 1'b0) begin
      fails++; $display("FAIL abort_passthrough: got addr=%0d data=%h wren=%b expected 5 5a 0", address_a, data_a, wren_a);
    end
    for (int i = 0; i < 4; i++) begin
      if (done !== 1'b0) seen++;
      tick;
    end
    checks++; if (seen != 0) begin fails++; $display("FAIL abort_no_done: got %0d done cycles expected 0", seen); end
    checks++; if (mem[0] !== 8'hB1 || mem[1] !== 8'hB2) begin fails++; $display("FAIL abort_ram: got %h %h expected b1 b2", mem[0], mem[1]); end
  endtask

  initial begin
    test_reset;
    test_clear;
    test_load;
    test_truncate;
`ifdef DPRAM_LOADER_VERIFY_EN
    test_verify;
`endif
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
